// File: rtl/mem_port_arbiter.sv
// Shares one RAM port between instruction fetch and the load/store unit, one
// transaction at a time, with byte-lane handling and a memory-mapped LED register.
module mem_port_arbiter #(
  parameter int unsigned     XLEN          = 32,
  parameter int unsigned     ALEN          = 32,
  parameter int unsigned     LED_WIDTH     = 4,
  parameter int unsigned     STARVE_LIMIT  = 4,
  parameter logic [ALEN-1:0] MMIO_LED_ADDR = {{(ALEN-4){1'b1}}, 4'h0}
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 if_req_valid,
  output logic                 if_req_ready,
  input  logic [ALEN-1:0]      if_req_addr,
  output logic                 if_rsp_valid,
  output logic [31:0]          if_rsp_data,
  input  logic                 d_req_valid,
  output logic                 d_req_ready,
  input  logic                 d_req_we,
  input  logic [2:0]           d_req_funct3,
  input  logic [ALEN-1:0]      d_req_addr,
  input  logic [XLEN-1:0]      d_req_wdata,
  output logic                 d_rsp_valid,
  output logic [XLEN-1:0]      d_rsp_rdata,
  output logic                 d_rsp_err,
  output logic                 mem_req,
  input  logic                 mem_gnt,
  output logic                 mem_we,
  output logic [3:0]           mem_be,
  output logic [ALEN-1:0]      mem_addr,
  output logic [XLEN-1:0]      mem_wdata,
  input  logic                 mem_rvalid,
  input  logic [XLEN-1:0]      mem_rdata,
  output logic [LED_WIDTH-1:0] led_out
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic [3:0]      STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [ALEN-1:0] WORD_MASK  = ~ALEN'(3);

  logic [1:0]      state;
  logic [3:0]      starve_cnt;
  logic            d_owner;
  logic            lat_we;
  logic [2:0]      lat_f3;
  logic [1:0]      lat_off;

  logic            idle;
  logic            starved;
  logic            if_acc;
  logic            d_acc;
  logic            d_bad_f3;
  logic            d_misal;
  logic            d_err;
  logic            d_mmio;
  logic [3:0]      st_be;
  logic [XLEN-1:0] st_wdata;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_ext;

  // D has priority unless IF has already been passed over STARVE_LIMIT times.
  always_comb begin
    idle         = (state == ST_IDLE);
    starved      = (starve_cnt == STARVE_MAX);
    if_req_ready = idle && if_req_valid && (!d_req_valid || starved);
    d_req_ready  = idle && d_req_valid && !(if_req_valid && starved);
    if_acc       = if_req_valid && if_req_ready;
    d_acc        = d_req_valid && d_req_ready;
  end

  always_comb begin
    d_bad_f3 = (d_req_funct3 == 3'b011) || (d_req_funct3[2:1] == 2'b11);
    d_misal  = ((d_req_funct3[1:0] == 2'b01) && d_req_addr[0]) ||
               ((d_req_funct3[1:0] == 2'b10) && (d_req_addr[1:0] != 2'b00));
    d_err    = d_bad_f3 || d_misal;
    d_mmio   = (d_req_addr == MMIO_LED_ADDR);
    case (d_req_funct3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << d_req_addr[1:0];
        st_wdata = XLEN'({4{d_req_wdata[7:0]}});
      end
      2'b01: begin
        st_be    = d_req_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = XLEN'({2{d_req_wdata[15:0]}});
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = d_req_wdata;
      end
    endcase
  end

  always_comb begin
    ld_byte = 8'(mem_rdata >> {lat_off, 3'b000});
    ld_half = lat_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (lat_f3)
      3'b000:  ld_ext = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b100:  ld_ext = XLEN'(ld_byte);
      3'b101:  ld_ext = XLEN'(ld_half);
      default: ld_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      starve_cnt   <= '0;
      d_owner      <= 1'b0;
      lat_we       <= 1'b0;
      lat_f3       <= '0;
      lat_off      <= '0;
      if_rsp_valid <= 1'b0;
      if_rsp_data  <= '0;
      d_rsp_valid  <= 1'b0;
      d_rsp_rdata  <= '0;
      d_rsp_err    <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_be       <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      led_out      <= '0;
    end else begin
      if_rsp_valid <= 1'b0;
      d_rsp_valid  <= 1'b0;
      d_rsp_err    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!if_req_valid || if_acc) begin
            starve_cnt <= '0;
          end else if (d_acc && !starved) begin
            starve_cnt <= starve_cnt + 4'd1;
          end
          if (if_acc) begin
            d_owner   <= 1'b0;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_be    <= 4'b1111;
            mem_addr  <= if_req_addr & WORD_MASK;
            mem_wdata <= '0;
            state     <= ST_ISSUE;
          end else if (d_acc) begin
            d_owner <= 1'b1;
            lat_we  <= d_req_we;
            lat_f3  <= d_req_funct3;
            lat_off <= d_req_addr[1:0];
            // Errors and LED accesses complete locally and respond next cycle.
            if (d_err) begin
              d_rsp_valid <= 1'b1;
              d_rsp_err   <= 1'b1;
              d_rsp_rdata <= '0;
              state       <= ST_RESP;
            end else if (d_mmio) begin
              d_rsp_valid <= 1'b1;
              if (d_req_we) begin
                led_out     <= d_req_wdata[LED_WIDTH-1:0];
                d_rsp_rdata <= '0;
              end else begin
                d_rsp_rdata <= XLEN'(led_out);
              end
              state <= ST_RESP;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= d_req_we;
              mem_be    <= d_req_we ? st_be : 4'b1111;
              mem_addr  <= d_req_addr & WORD_MASK;
              mem_wdata <= d_req_we ? st_wdata : '0;
              state     <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            if (d_owner) begin
              d_rsp_valid <= 1'b1;
              d_rsp_rdata <= lat_we ? '0 : ld_ext;
            end else begin
              if_rsp_valid <= 1'b1;
              if_rsp_data  <= mem_rdata[31:0];
            end
            state <= ST_RESP;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: byte-addressed reference memory and LED model,
// a randomized RAM responder, directed corner cases and a random traffic mix.
module tb_mem_port_arbiter;

  localparam logic [31:0] LED_ADDR = 32'hFFFF_FFF0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req_valid, if_req_ready, if_rsp_valid;
  logic [31:0] if_req_addr, if_rsp_data;
  logic        d_req_valid, d_req_ready, d_req_we, d_rsp_valid, d_rsp_err;
  logic [2:0]  d_req_funct3;
  logic [31:0] d_req_addr, d_req_wdata, d_rsp_rdata;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [3:0]  mem_be, led_out;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        manual = 1'b0, m_gnt = 1'b0, m_rvalid = 1'b0;
  logic [31:0] m_rdata = '0;
  logic        a_gnt = 1'b0, a_rvalid = 1'b0;
  logic [31:0] a_rdata = '0;
  assign mem_gnt    = manual ? m_gnt    : a_gnt;
  assign mem_rvalid = manual ? m_rvalid : a_rvalid;
  assign mem_rdata  = manual ? m_rdata  : a_rdata;

  int unsigned gnt_stall = 0, lat_max = 0;
  int          checks = 0, failures = 0, cyc = 0, rv_cyc = 0;
  logic [7:0]  mref [0:1023];
  logic [31:0] ram  [0:255];
  logic [3:0]  led_ref = '0;
  logic [31:0] cap_addr = '0, cap_wdata = '0;
  logic [3:0]  cap_be = '0;
  logic        cap_we = 1'b0;
  int unsigned dly = 0;
  bit          busy = 0;

  mem_port_arbiter #(.XLEN(32), .ALEN(32), .LED_WIDTH(4), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
    .d_req_funct3(d_req_funct3), .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata), .d_rsp_err(d_rsp_err),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .led_out(led_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM responder: grants after a random stall, answers after a random delay.
  always @(negedge clk) begin
    if (!rst_n) begin
      a_gnt = 1'b0; a_rvalid = 1'b0; busy = 0;
      for (int i = 0; i < 256; i++)
        ram[i] = {mref[4*i+3], mref[4*i+2], mref[4*i+1], mref[4*i]};
    end else if (!manual) begin
      a_rvalid = 1'b0;
      if (a_gnt) begin
        a_gnt = 1'b0; busy = 1; dly = $urandom_range(0, lat_max);
        cap_addr = mem_addr; cap_we = mem_we; cap_be = mem_be; cap_wdata = mem_wdata;
      end else if (!busy && mem_req && $urandom_range(0, gnt_stall) == 0) begin
        a_gnt = 1'b1;
      end
      if (busy) begin
        if (dly == 0) begin
          a_rdata = ram[cap_addr[9:2]];
          for (int b = 0; b < 4; b++)
            if (cap_we && cap_be[b]) ram[cap_addr[9:2]][8*b +: 8] = cap_wdata[8*b +: 8];
          a_rvalid = 1'b1; busy = 0; rv_cyc = cyc;
        end else begin
          dly--;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mword(input logic [31:0] a);
    logic [31:0] w = a & 32'h0000_03FC;
    return {mref[w+3], mref[w+2], mref[w+1], mref[w]};
  endfunction

  task automatic model_d(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] erd,
                         output bit eerr, output bit eram);
    int n; bit sgn; longint v;
    erd = '0; eerr = 0; eram = 0; sgn = 0; v = 0; n = 0;
    case (f3)
      3'd0: begin n = 1; sgn = 1; end
      3'd1: begin n = 2; sgn = 1; end
      3'd2: n = 4;
      3'd4: n = 1;
      3'd5: n = 2;
      default: n = 0;
    endcase
    if (n == 0 || (int'(addr[1:0]) % n) != 0) begin eerr = 1; return; end
    if (addr == LED_ADDR) begin
      if (we) led_ref = wd[3:0]; else erd = 32'(led_ref);
      return;
    end
    eram = 1;
    for (int i = 0; i < n; i++) begin
      if (we) mref[addr+i] = wd[8*i +: 8];
      else v = v | (longint'(mref[addr+i]) << (8*i));
    end
    if (!we && sgn && v[8*n-1]) v = v - (longint'(1) << (8*n));
    erd = we ? 32'd0 : v[31:0];
  endtask

  task automatic d_txn(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output logic [31:0] rd, output bit er,
                       output int lat, output bit sr, output int rsp_cyc);
    int guard, t0;
    rd = '0; er = 0; lat = -1; sr = 0; rsp_cyc = 0; guard = 0;
    @(posedge clk); #1;
    d_req_valid = 1'b1; d_req_we = we; d_req_funct3 = f3; d_req_addr = addr; d_req_wdata = wd;
    @(negedge clk);
    while (!d_req_ready && guard < 100) begin @(negedge clk); guard++; end
    if (!d_req_ready) begin check("d_accept_timeout", 32'd0, 32'd1); d_req_valid = 1'b0; return; end
    t0 = cyc;
    @(posedge clk); #1; d_req_valid = 1'b0;
    guard = 0;
    @(negedge clk);
    while (!d_rsp_valid && guard < 100) begin
      if (mem_req) sr = 1;
      @(negedge clk); guard++;
    end
    if (!d_rsp_valid) begin check("d_rsp_timeout", 32'd0, 32'd1); return; end
    lat = cyc - t0; rsp_cyc = cyc; rd = d_rsp_rdata; er = d_rsp_err;
    @(negedge clk);
    check("d_rsp_pulse", 32'(d_rsp_valid), 32'd0);
  endtask

  task automatic if_txn(input logic [31:0] addr, output logic [31:0] rd);
    int guard;
    rd = '0; guard = 0;
    @(posedge clk); #1;
    if_req_valid = 1'b1; if_req_addr = addr;
    @(negedge clk);
    while (!if_req_ready && guard < 100) begin @(negedge clk); guard++; end
    if (!if_req_ready) begin check("if_accept_timeout", 32'd0, 32'd1); if_req_valid = 1'b0; return; end
    @(posedge clk); #1; if_req_valid = 1'b0;
    guard = 0;
    @(negedge clk);
    while (!if_rsp_valid && guard < 100) begin @(negedge clk); guard++; end
    if (!if_rsp_valid) begin check("if_rsp_timeout", 32'd0, 32'd1); return; end
    rd = if_rsp_data;
    check("if_no_d_rsp", 32'(d_rsp_valid), 32'd0);
  endtask

  task automatic run_d(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
    logic [31:0] erd, rd; bit eer, eram, er, sr; int lat, rc;
    model_d(we, f3, addr, wd, erd, eer, eram);
    d_txn(we, f3, addr, wd, rd, er, lat, sr, rc);
    check("d_rdata", rd, erd);
    check("d_err", 32'(er), 32'(eer));
    check("d_ram_access", 32'(sr), 32'(eram));
    if (!eram) check("d_local_lat", 32'(lat), 32'd1);
    else check("d_ram_lat_ge3", 32'(lat >= 3), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, erd, exp_if;
    bit er, sr, eer, eram, who_if;
    int lat, rc, guard;

    if_req_valid = 1'b0; if_req_addr = '0;
    d_req_valid = 1'b0; d_req_we = 1'b0; d_req_funct3 = '0; d_req_addr = '0; d_req_wdata = '0;
    for (int i = 0; i < 1024; i++) mref[i] = 8'($urandom);
    {mref[259], mref[258], mref[257], mref[256]} = 32'h80FF_7F01;

    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_be", 32'(mem_be), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_rsp_valid", 32'({if_rsp_valid, d_rsp_valid, d_rsp_err}), 32'd0);
    check("rst_led", 32'(led_out), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Load extension at zero-stall RAM timing.
    d_txn(1'b0, 3'd0, 32'h103, '0, rd, er, lat, sr, rc);
    check("lb_0x103", rd, 32'hFFFF_FF80);
    check("lb_latency", 32'(lat), 32'd3);
    d_txn(1'b0, 3'd4, 32'h103, '0, rd, er, lat, sr, rc);
    check("lbu_0x103", rd, 32'h0000_0080);
    d_txn(1'b0, 3'd1, 32'h102, '0, rd, er, lat, sr, rc);
    check("lh_0x102", rd, 32'hFFFF_80FF);

    model_d(1'b1, 3'd1, 32'h206, 32'hABCD_1234, erd, eer, eram);
    d_txn(1'b1, 3'd1, 32'h206, 32'hABCD_1234, rd, er, lat, sr, rc);
    check("sh_addr", cap_addr, 32'h204);
    check("sh_be", 32'(cap_be), 32'hC);
    check("sh_wdata", cap_wdata, 32'h1234_1234);
    check("sh_we", 32'(cap_we), 32'd1);
    check("sh_rsp_after_rvalid", 32'(rc - rv_cyc), 32'd1);
    run_d(1'b0, 3'd2, 32'h204, '0);

    model_d(1'b1, 3'd2, LED_ADDR, 32'hA, erd, eer, eram);
    d_txn(1'b1, 3'd2, LED_ADDR, 32'hA, rd, er, lat, sr, rc);
    check("led_store_value", 32'(led_out), 32'hA);
    check("led_store_lat", 32'(lat), 32'd1);
    check("led_store_no_mem", 32'(sr), 32'd0);
    d_txn(1'b0, 3'd2, LED_ADDR, '0, rd, er, lat, sr, rc);
    check("led_load", rd, 32'hA);

    d_txn(1'b0, 3'd2, 32'h101, '0, rd, er, lat, sr, rc);
    check("err_lw_misal", 32'({er, sr, rd != 0}), 32'b100);
    d_txn(1'b0, 3'd1, 32'h103, '0, rd, er, lat, sr, rc);
    check("err_lh_misal", 32'({er, sr, rd != 0}), 32'b100);
    d_txn(1'b0, 3'd3, 32'h100, '0, rd, er, lat, sr, rc);
    check("err_funct3_011", 32'({er, sr, rd != 0}), 32'b100);

    // Both requesters held valid: IF must be forced through every fifth grant.
    @(posedge clk); #1;
    if_req_valid = 1'b1; if_req_addr = 32'h40;
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_funct3 = 3'd2; d_req_addr = 32'h100; d_req_wdata = '0;
    model_d(1'b0, 3'd2, 32'h100, '0, erd, eer, eram);
    for (int g = 0; g < 10; g++) begin
      guard = 0;
      @(negedge clk);
      while (!if_req_ready && !d_req_ready && guard < 50) begin @(negedge clk); guard++; end
      who_if = if_req_ready;
      check("arb_grant_is_if", 32'(who_if), 32'((g % 5) == 4));
      exp_if = mword(if_req_addr);
      @(posedge clk); #1;
      if (who_if) if_req_addr = if_req_addr + 32'd4;
      guard = 0;
      @(negedge clk);
      while (!if_rsp_valid && !d_rsp_valid && guard < 100) begin @(negedge clk); guard++; end
      check("arb_rsp_owner", 32'({if_rsp_valid, d_rsp_valid}), who_if ? 32'b10 : 32'b01);
      if (who_if) check("arb_if_data", if_rsp_data, exp_if);
      else check("arb_d_data", d_rsp_rdata, erd);
    end
    @(posedge clk); #1; if_req_valid = 1'b0; d_req_valid = 1'b0;

    // Reset while waiting on RAM, then stray handshakes must be ignored.
    manual = 1'b1;
    @(posedge clk); #1;
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_funct3 = 3'd2; d_req_addr = 32'h100;
    guard = 0;
    @(negedge clk);
    while (!d_req_ready && guard < 50) begin @(negedge clk); guard++; end
    @(posedge clk); #1; d_req_valid = 1'b0;
    @(negedge clk);
    check("mid_issue_req", 32'(mem_req), 32'd1);
    m_gnt = 1'b1;
    @(negedge clk); m_gnt = 1'b0;
    #1 rst_n = 1'b0; #1;
    check("mid_rst_mem", 32'({mem_req, mem_we, mem_be}), 32'd0);
    check("mid_rst_addr", mem_addr, 32'd0);
    check("mid_rst_led", 32'(led_out), 32'd0);
    check("mid_rst_rsp", 32'({d_rsp_valid, if_rsp_valid, d_rsp_err}), 32'd0);
    led_ref = '0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); m_rvalid = 1'b1; m_rdata = 32'hDEAD_BEEF;
    @(negedge clk); m_rvalid = 1'b0; m_gnt = 1'b1;
    @(negedge clk); m_gnt = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("stray_no_activity", 32'({d_rsp_valid, if_rsp_valid, mem_req}), 32'd0);
      @(negedge clk);
    end
    manual = 1'b0;
    run_d(1'b0, 3'd2, 32'h100, '0);

    gnt_stall = 2; lat_max = 3;
    for (int t = 0; t < 200; t++) begin
      if ($urandom_range(0, 4) == 0) begin
        logic [31:0] a = $urandom_range(0, 1023);
        exp_if = mword(a);
        if_txn(a, rd);
        check("rnd_if_data", rd, exp_if);
      end else begin
        logic [31:0] a = $urandom_range(0, 1023);
        logic [3:0]  f = 4'($urandom_range(0, 9));
        logic [2:0]  f3 = (f > 4'd7) ? 3'd2 : f[2:0];
        if ($urandom_range(0, 1) == 1) a = a & 32'hFFFF_FFFC;
        if ($urandom_range(0, 9) == 0) a = LED_ADDR;
        run_d(1'($urandom_range(0, 1)), f3, a, $urandom);
      end
    end
    check("rnd_led_final", 32'(led_out), 32'(led_ref));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
